// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder is stepped across two WIDTH-bit operands,
// LSB first, one bit per clock. Latency is WIDTH+1 edges from accept to IDLE.

// Single-bit full adder; the controller below time-multiplexes one instance.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    // Counter must hold 0..WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_next;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             fa_sum;
    logic             fa_carry;

    full_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Result shifts right; the fresh sum bit enters at the MSB.
    always_comb begin
        // NOTE: assign a full default first so every path drives it -- no latch.
        result_next            = result >> 1;
        result_next[WIDTH-1]   = fa_sum;
    end

    // Control FSM and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so all flops update together.
        if (reset) begin
            // NOTE: every register here is a plain flop (no memory), so all are cleared.
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            result  <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    result  <= result_next;
                    carry_q <= fa_carry;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // carry_q is the carry into the MSB at this point.
                        ovf_q  <= carry_q ^ fa_carry;
                        cout_q <= fa_carry;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sum  = result;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state == ADD);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): stimulus pushes expected
// {sum,cout,ovf}; a monitor pops and compares whenever done is high.
module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    logic [WIDTH+1:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (op_a),
        .b     (op_b),
        .cin   (op_cin),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        logic [WIDTH+1:0] exp;
        if (!reset && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 sum=%h, required no pending operation", sum);
            end else begin
                exp = exp_q.pop_front();
                if ({sum, cout, ovf} !== exp) begin
                    errors++;
                    $display("FAIL result: got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                             sum, cout, ovf, exp[WIDTH+1:2], exp[1], exp[0]);
                end
            end
        end
    end

    // Wait (at negedges) until the DUT is idle, bounded.
    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("idle_timeout", 32'(busy | done), 0);
    endtask

    // One operation: called at a negedge; returns at the negedge after done.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input logic [7:0] es, input logic ec, input logic eo,
                          input bit timing);
        int n;
        int bc;
        wait_idle();
        op_a = va; op_b = vb; op_cin = vc; start = 1'b1;
        exp_q.push_back({es, ec, eo});
        @(negedge clk);
        start = 1'b0;
        n = 0; bc = 0;
        while (!done && n < WIDTH + 4) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        if (timing) begin
            check("busy_cycles", bc, WIDTH);
            check("done_latency", n, WIDTH);
        end
        check("done_seen", 32'(done), 1);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);
    endtask

    initial begin
        int n;
        int bc;
        int done_cnt;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] full;
        logic       rovf;

        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {sum, cout, ovf, busy, done}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed arithmetic vectors.
        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b1 ^ 1'b1, 1'b1, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

        // Results hold with start low.
        for (int i = 0; i < 20; i++) begin
            check("hold_result", {sum, cout, ovf}, {8'hFF, 1'b1, 1'b0});
            check("hold_done", 32'(done), 0);
            @(negedge clk);
        end

        // start held high, operands changed after accept.
        wait_idle();
        op_a = 8'h12; op_b = 8'h34; op_cin = 1'b0; start = 1'b1;
        exp_q.push_back({8'h46, 1'b0, 1'b0});
        @(negedge clk);
        op_a = 8'hFF; op_b = 8'hFF;
        n = 0; bc = 0;
        while (!done && n < WIDTH + 4) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        check("held_start_busy_cycles", bc, WIDTH);
        check("held_start_done_seen", 32'(done), 1);
        // Next accept is the following edge (first in IDLE): FF+FF.
        exp_q.push_back({8'hFE, 1'b1, 1'b0});
        @(negedge clk);
        check("idle_gap", {busy, done}, 0);
        @(negedge clk);
        start = 1'b0;
        check("reaccept_busy", 32'(busy), 1);
        n = 0;
        while (!done && n < WIDTH + 4) begin
            @(negedge clk);
            n++;
        end
        check("reaccept_done_seen", 32'(done), 1);
        @(negedge clk);

        // Reset in the 4th ADD cycle aborts without a done pulse.
        wait_idle();
        op_a = 8'h0F; op_b = 8'h0F; op_cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_outputs", {sum, cout, ovf, busy, done}, 0);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);

        // 256 random vectors against a+b+cin.
        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            rovf = (ra[7] == rb[7]) && (full[7] != ra[7]);
            run_op(ra, rb, rc, full[7:0], full[8], rovf, 1'b0);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
